rr_arbiter_n: RTL and testbench
===============================

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 SHALL provide parameter NUMBER_OF_CLIENTS, default 4, number of requesting clients (legal range 2..16).
REQ-002 SHALL provide parameter ADDR_WIDTH, default $clog2(NUMBER_OF_CLIENTS), width of the served-address output.
REQ-003 SHALL provide parameter ACK_TIMEOUT, default 16, maximum BUSY cycles without server_ack (0 = timeout disabled).
REQ-004 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port enable, input, 1, allows new grants when high.
REQ-007 SHALL provide port client_rq, input, NUMBER_OF_CLIENTS, per-client request level; bit i = client i.
REQ-008 SHALL provide port server_ack, input, 1, server completion of the current grant.
REQ-009 SHALL provide port grant, output reg, NUMBER_OF_CLIENTS, one-hot grant.
REQ-010 SHALL provide port grant_valid, output reg, 1, high while a grant is held.
REQ-011 SHALL provide port address_to_be_served, output reg, ADDR_WIDTH, binary index of the granted client.
REQ-012 SHALL provide port timeout_err, output reg, 1, one-cycle pulse on ack timeout.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-014 SHALL keep a one-hot last-served pointer of NUMBER_OF_CLIENTS bits; search order starts at the index after the last-served index and wraps from N-1 to 0.
REQ-015 IDLE -> BUSY when enable=1 and client_rq != 0; on that edge grant, grant_valid=1 and address_to_be_served register the first requesting client in search order (latency 1 cycle from sampled request).
REQ-016 In IDLE with enable=0 or client_rq=0, SHALL keep grant=0, grant_valid=0, address_to_be_served unchanged.
REQ-017 In BUSY, grant and address_to_be_served SHALL stay stable regardless of client_rq or enable changes.
REQ-018 BUSY -> IDLE on server_ack=1: next edge clears grant and grant_valid, loads pointer with the granted client.
REQ-019 After any release there SHALL be at least one IDLE cycle before the next grant.
REQ-020 server_ack in IDLE SHALL be ignored.
REQ-021 With ACK_TIMEOUT>0, a BUSY-cycle counter of width $clog2(ACK_TIMEOUT+1) SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-022 When the counter reaches ACK_TIMEOUT without ack, the next edge SHALL release as in REQ-018 and pulse timeout_err for exactly one cycle.
REQ-023 server_ack and timeout in the same cycle SHALL be treated as ack; no timeout_err.
REQ-024 With ACK_TIMEOUT=0, the counter SHALL be absent, timeout_err tied 0, and BUSY held until ack.
REQ-025 grant SHALL be zero or one-hot at all times; grant_valid SHALL equal (grant != 0).

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, grant=0, grant_valid=0, address_to_be_served=0, timeout_err=0, counter=0.
REQ-027 reset SHALL load the pointer with bit NUMBER_OF_CLIENTS-1 set (client 0 highest priority after reset).
REQ-028 reset asserted during BUSY SHALL drop the grant immediately without waiting for server_ack or a clock edge.

Verification
REQ-029 After reset, N=4, client_rq=4'b1111, enable=1, ack 2 cycles after each grant -> address sequence 0,1,2,3,0, one IDLE cycle between grants.
REQ-030 client_rq=4'b1010 from reset -> grant 4'b0010 (address 1); after ack, grant 4'b1000 (address 3); after ack, address 1 again.
REQ-031 Grant client 2, drop client_rq[2] and set enable=0 while BUSY -> grant stays 4'b0100 until ack.
REQ-032 ACK_TIMEOUT=16, grant held with no ack -> release after 16 BUSY cycles, timeout_err high exactly one cycle, next grant goes to following requester.
REQ-033 server_ack coincident with timeout cycle -> release, timeout_err stays 0; server_ack while IDLE -> no state change.
REQ-034 Assert reset mid-BUSY (between clock edges) -> grant=0 immediately; after release, client_rq=4'b1111 grants address 0.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: one grant held until server_ack or ack timeout.
// Ports: clk/reset, enable, client_rq in; grant, grant_valid,
//        address_to_be_served, timeout_err out.
module rr_arbiter_n #(
  parameter int NUMBER_OF_CLIENTS = 4,
  parameter int ADDR_WIDTH = $clog2(NUMBER_OF_CLIENTS),
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUMBER_OF_CLIENTS-1:0] client_rq,
  input  logic                         server_ack,
  output logic [NUMBER_OF_CLIENTS-1:0] grant,
  output logic                         grant_valid,
  output logic [ADDR_WIDTH-1:0]        address_to_be_served,
  output logic                         timeout_err
);

  localparam int N = NUMBER_OF_CLIENTS;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [N-1:0]    ptr, ptr_n;
  logic [N-1:0]    grant_n;
  logic            gv_n;
  logic [AW-1:0]   addr_n;
  logic            terr_n;
  logic            to_hit;
  logic            pick_found;
  logic [AW-1:0]   pick_idx;
  int              last_idx;

  always_comb begin
    last_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) last_idx = i;
    end
  end

  // Walk from the farthest candidate back to the nearest so the
  // last hit is the first requester after the last-served client.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (client_rq[(last_idx + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = AW'((last_idx + k) % N);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    gv_n    = grant_valid;
    addr_n  = address_to_be_served;
    ptr_n   = ptr;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        gv_n    = 1'b0;
        if (enable && pick_found) begin
          state_n = BUSY;
          grant_n = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          gv_n    = 1'b1;
          addr_n  = pick_idx;
        end
      end
      BUSY: begin
        if (server_ack || to_hit) begin
          state_n = IDLE;
          grant_n = '0;
          gv_n    = 1'b0;
          ptr_n   = grant;
          // An ack in the timeout cycle wins: no error.
          terr_n  = !server_ack;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      grant                <= '0;
      grant_valid          <= 1'b0;
      address_to_be_served <= '0;
      ptr                  <= {1'b1, {(N-1){1'b0}}};
    end else begin
      state                <= state_n;
      grant                <= grant_n;
      grant_valid          <= gv_n;
      address_to_be_served <= addr_n;
      ptr                  <= ptr_n;
    end
  end

  if (ACK_TIMEOUT > 0) begin : g_to
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(ACK_TIMEOUT);

    logic [CW-1:0] cnt;

    assign to_hit = (state == BUSY) && (cnt == TO_MAX);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (state == BUSY && !server_ack && !to_hit) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) timeout_err <= 1'b0;
      else       timeout_err <= terr_n;
    end
  end else begin : g_no_to
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, ACK_TIMEOUT=16).
// Hand-computed grant order, hold, timeout and async reset.
module tb_rr_arbiter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       server_ack;
  logic [3:0] client_rq;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] address_to_be_served;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(
    .NUMBER_OF_CLIENTS(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .client_rq(client_rq),
    .server_ack(server_ack),
    .grant(grant),
    .grant_valid(grant_valid),
    .address_to_be_served(address_to_be_served),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic ack_once;
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("onehot", {31'b0, $onehot0(grant)}, 32'd1);
    chk("gv_match", {31'b0, grant_valid}, {31'b0, |grant});
  end

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    server_ack = 1'b0;
    client_rq  = 4'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_addr", address_to_be_served, 0);
    chk("rst_terr", timeout_err, 0);
    tick();
    reset = 1'b0;

    // round robin over all four clients
    client_rq = 4'hF;
    enable    = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("seq_grant", grant, 4'b0001 << seq[i]);
      chk("seq_addr", address_to_be_served, seq[i]);
      tick();
      ack_once();
      chk("seq_idle", grant_valid, 0);
      tick();
    end

    // sparse requesters 1 and 3
    do_reset();
    client_rq = 4'b1010;
    tick();
    chk("sp_grant1", grant, 4'b0010);
    chk("sp_addr1", address_to_be_served, 1);
    tick();
    ack_once();
    chk("sp_idle", grant_valid, 0);
    tick();
    chk("sp_grant3", grant, 4'b1000);
    chk("sp_addr3", address_to_be_served, 3);
    tick();
    ack_once();
    tick();
    chk("sp_grant1b", grant, 4'b0010);
    chk("sp_addr1b", address_to_be_served, 1);

    // grant held while request and enable drop
    do_reset();
    client_rq = 4'b0100;
    tick();
    chk("hold_grant0", grant, 4'b0100);
    client_rq = 4'b0;
    enable    = 1'b0;
    repeat (3) tick();
    chk("hold_grant", grant, 4'b0100);
    chk("hold_addr", address_to_be_served, 2);
    ack_once();
    chk("hold_rel", grant_valid, 0);
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_addr", address_to_be_served, 2);

    // timeout with no ack
    do_reset();
    client_rq = 4'b0011;
    enable    = 1'b1;
    tick();
    chk("to_grant", grant, 4'b0001);
    repeat (16) tick();
    chk("to_held", grant_valid, 1);
    chk("to_noerr", timeout_err, 0);
    tick();
    chk("to_rel", grant_valid, 0);
    chk("to_err", timeout_err, 1);
    tick();
    chk("to_err_end", timeout_err, 0);
    chk("to_next", grant, 4'b0010);
    chk("to_next_addr", address_to_be_served, 1);

    // ack in the timeout cycle, then ack while idle
    repeat (16) tick();
    ack_once();
    chk("co_rel", grant_valid, 0);
    chk("co_noerr", timeout_err, 0);
    enable = 1'b0;
    ack_once();
    chk("ia_gv", grant_valid, 0);
    chk("ia_addr", address_to_be_served, 1);
    chk("ia_terr", timeout_err, 0);
    enable = 1'b1;
    tick();
    chk("ia_next", grant, 4'b0001);

    // async reset between edges
    do_reset();
    client_rq = 4'b0100;
    tick();
    chk("ar_grant0", grant, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_gv", grant_valid, 0);
    chk("ar_addr", address_to_be_served, 0);
    #1;
    reset     = 1'b0;
    client_rq = 4'hF;
    tick();
    chk("ar_next", grant, 4'b0001);
    chk("ar_next_addr", address_to_be_served, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
